// File: rtl/timer_device_if.sv
// Bridge-side register port of the timer: word address, write data, write
// enable, combinational read data and the interrupt request line.
interface timer_device_if;
    logic [31:2] Addr;
    logic [31:0] WData;
    logic        WE;
    logic [31:0] RData;
    logic        IRQ;

    // Bridge side drives the access, the timer returns data and interrupt.
    modport master (output Addr, WData, WE, input RData, IRQ);
    modport slave  (input Addr, WData, WE, output RData, IRQ);
endinterface

// File: rtl/timer_device.sv
// Programmable 32-bit down-counter with one-shot (mode 0) and auto-reload
// (mode 1) operation, register access through the bridge port and a
// maskable interrupt request.
//
// Bus protocol: there is no valid/ready pair. A write is accepted on every
// rising clk edge where WE=1 and lands in the register selected by
// Addr[3:2]. RData is a pure function of Addr[3:2] and the current register
// contents, so a read completes in the same cycle with no side effects.
module timer_device #(
    parameter logic [31:0] RESET_PRESET = 32'h0
) (
    input  logic             clk,
    input  logic             reset,
    timer_device_if.slave    bus,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CNT  = 2'd1,
        INT  = 2'd2
    } state_t;

    localparam logic [1:0] SEL_CTRL   = 2'd0;
    localparam logic [1:0] SEL_PRESET = 2'd1;
    localparam logic [1:0] SEL_COUNT  = 2'd2;

    state_t      state, state_n;
    logic [3:0]  ctrl, ctrl_n;       // [0] EN, [2:1] MODE, [3] IM
    logic [31:0] preset, preset_n;
    logic [31:0] count, count_n;
    logic        irq_flag, irq_flag_n;

    logic        en;
    logic        periodic;
    logic        ctrl_wr;

    // Only Addr[3:2] selects a register; the rest of the word address is
    // already qualified by the bridge.
    logic        unused_addr;
    assign unused_addr = ^bus.Addr[31:4];

    assign en       = ctrl[0];
    assign periodic = (ctrl[2:1] == 2'b01);
    assign ctrl_wr  = bus.WE && (bus.Addr[3:2] == SEL_CTRL);

    // Register update: synchronous active-low reset, otherwise take next values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            ctrl     <= 4'h0;
            preset   <= RESET_PRESET;
            count    <= 32'h0;
            irq_flag <= 1'b0;
        end else begin
            state    <= state_n;
            ctrl     <= ctrl_n;
            preset   <= preset_n;
            count    <= count_n;
            irq_flag <= irq_flag_n;
        end
    end

    // Counter FSM and register writes; a CPU write overrides the FSM's own
    // updates of CTRL and irq_flag on the same edge.
    always_comb begin
        state_n    = state;
        ctrl_n     = ctrl;
        preset_n   = preset;
        count_n    = count;
        irq_flag_n = irq_flag;

        case (state)
            IDLE: begin
                if (en) begin
                    count_n = preset;
                    state_n = CNT;
                end
            end
            CNT: begin
                if (!en) begin
                    state_n = IDLE;
                end else if (count > 32'd1) begin
                    count_n = count - 32'd1;
                end else begin
                    // Terminal count; 0 and 1 both expire so COUNT never wraps.
                    count_n    = 32'h0;
                    irq_flag_n = 1'b1;
                    state_n    = INT;
                end
            end
            INT: begin
                if (periodic) begin
                    // Leave EN set so IDLE reloads on the next edge.
                    irq_flag_n = 1'b0;
                end else begin
                    ctrl_n[0] = 1'b0;
                end
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (ctrl_wr) begin
            ctrl_n = bus.WData[3:0];
            // A CTRL write acknowledges the interrupt, except a write that
            // flips IM: masking or unmasking leaves a pending flag in place.
            if (bus.WData[3] == ctrl[3]) begin
                irq_flag_n = 1'b0;
            end
        end
        if (bus.WE && (bus.Addr[3:2] == SEL_PRESET)) begin
            preset_n = bus.WData;
        end
    end

    // Read mux; COUNT is read-only and offset 3 reads as zero.
    always_comb begin
        bus.RData = 32'h0;
        case (bus.Addr[3:2])
            SEL_CTRL:   bus.RData = {28'h0, ctrl};
            SEL_PRESET: bus.RData = preset;
            SEL_COUNT:  bus.RData = count;
            default:    bus.RData = 32'h0;
        endcase
    end

    assign bus.IRQ   = ctrl[3] & irq_flag;
    assign dbg_state = state;

endmodule
